// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with a sequenced clear sweep.
// Reads are combinational and forced to zero while a sweep is in progress.
//
// state      | meaning
// -----------+-----------------------------------------------------
// S_IDLE     | normal operation: writes accepted, reads show storage
// S_CLEARING | sweep zeroes one entry per cycle, reads forced to 0
module regfile_2r1w #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] qa,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] qb,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   wr_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_CLEARING = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_written;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_wr_count;
  logic                  w_wr_en;
  logic                  w_start_clr;
  logic                  w_sweep_last;

  assign w_sweep_last = (r_ptr == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (clr) w_state_nxt = S_CLEARING;
      S_CLEARING: if (w_sweep_last) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // clr has priority over load in IDLE; both are ignored while clearing
  always_comb begin
    busy        = (r_state == S_CLEARING);
    w_start_clr = (r_state == S_IDLE) && clr;
    w_wr_en     = (r_state == S_IDLE) && load && !clr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_written  <= '0;
      r_ptr      <= '0;
      r_wr_count <= '0;
    end else if (w_start_clr) begin
      r_written  <= '0;
      r_ptr      <= '0;
      r_wr_count <= '0;
    end else if (busy) begin
      r_mem[r_ptr] <= '0;
      r_ptr        <= r_ptr + 1'b1;
    end else if (w_wr_en) begin
      r_mem[waddr]     <= din;
      r_written[waddr] <= 1'b1;
      if (!r_written[waddr]) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign qa       = busy ? '0 : r_mem[raddr_a];
  assign qb       = busy ? '0 : r_mem[raddr_b];
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed and random checks of regfile_2r1w at DATA_WIDTH=4, ADDR_WIDTH=3.
module tb_regfile_2r1w;
  logic       clk = 1'b0;
  logic       rst_n, load, clr;
  logic [2:0] waddr, raddr_a, raddr_b;
  logic [3:0] din, qa, qb, wr_count;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_mem [8];
  logic       m_wr  [8];
  int         m_cnt;

  regfile_2r1w #(.DATA_WIDTH(4), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .waddr(waddr), .din(din),
    .clr(clr), .raddr_a(raddr_a), .qa(qa), .raddr_b(raddr_b), .qb(qb),
    .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [2:0] ra, input logic [2:0] rb,
                          input logic [3:0] ea, input logic [3:0] eb);
    raddr_a = ra;
    raddr_b = rb;
    #1;
    chk({tag, "_qa"}, {4'h0, qa}, {4'h0, ea});
    chk({tag, "_qb"}, {4'h0, qb}, {4'h0, eb});
  endtask

  task automatic write_one(input logic [2:0] a, input logic [3:0] d);
    load  = 1'b1;
    waddr = a;
    din   = d;
    clk_step();
    load  = 1'b0;
  endtask

  initial begin
    int w;
    logic [2:0] ra, rb;
    rst_n = 1'b0; load = 1'b0; clr = 1'b0;
    waddr = '0; din = '0; raddr_a = '0; raddr_b = '0;

    // Test 1: reset
    clk_step();
    clk_step();
    rst_n = 1'b1;
    chk("t1_busy", {7'h0, busy}, 8'h00);
    chk("t1_cnt", {4'h0, wr_count}, 8'h00);
    for (int i = 0; i < 8; i++) read_chk("t1_rd", 3'(i), 3'(i), 4'h0, 4'h0);

    // Test 2: fill, with no-bypass check before each storing edge
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; waddr = 3'(i); din = 4'(1 + i);
      raddr_a = 3'(i);
      #1;
      chk("t2_nobypass", {4'h0, qa}, 8'h00);
      clk_step();
      chk("t2_cnt", {4'h0, wr_count}, 8'(i + 1));
    end
    load = 1'b0;
    for (int i = 0; i < 8; i++) read_chk("t2_rd", 3'(i), 3'(7 - i), 4'(1 + i), 4'(8 - i));

    // Test 3: rewrite leaves count alone; same address on both ports
    write_one(3'd3, 4'hA);
    read_chk("t3_first", 3'd3, 3'd3, 4'hA, 4'hA);
    chk("t3_cnt1", {4'h0, wr_count}, 8'h08);
    write_one(3'd3, 4'h5);
    read_chk("t3_second", 3'd3, 3'd3, 4'h5, 4'h5);
    chk("t3_cnt2", {4'h0, wr_count}, 8'h08);

    // Test 4: clear sweep, with load and clr attempts while busy
    clr = 1'b1;
    clk_step();
    clr = 1'b0;
    chk("t4_cnt_busy", {4'h0, wr_count}, 8'h00);
    for (int k = 0; k < 8; k++) begin
      raddr_a = 3'(k);
      raddr_b = 3'(7 - k);
      #1;
      chk("t4_busy", {7'h0, busy}, 8'h01);
      chk("t4_qa_busy", {4'h0, qa}, 8'h00);
      chk("t4_qb_busy", {4'h0, qb}, 8'h00);
      load = (k == 3);
      waddr = 3'd2;
      din = 4'hF;
      clr = (k == 5);
      clk_step();
      load = 1'b0;
      clr = 1'b0;
    end
    chk("t4_busy_end", {7'h0, busy}, 8'h00);
    chk("t4_cnt_end", {4'h0, wr_count}, 8'h00);
    for (int i = 0; i < 8; i++) read_chk("t4_rd", 3'(i), 3'(7 - i), 4'h0, 4'h0);

    // Test 5: load and clr together, clr wins
    write_one(3'd4, 4'h3);
    read_chk("t5_pre", 3'd4, 3'd4, 4'h3, 4'h3);
    load = 1'b1; waddr = 3'd4; din = 4'hC; clr = 1'b1;
    clk_step();
    load = 1'b0; clr = 1'b0;
    chk("t5_busy", {7'h0, busy}, 8'h01);
    w = 0;
    while (busy && w < 20) begin
      clk_step();
      w++;
    end
    chk("t5_busy_len", 8'(w), 8'h08);
    read_chk("t5_e4", 3'd4, 3'd4, 4'h0, 4'h0);
    chk("t5_cnt", {4'h0, wr_count}, 8'h00);

    // Test 6: reset aborts a sweep
    write_one(3'd5, 4'h9);
    write_one(3'd6, 4'h7);
    write_one(3'd7, 4'hE);
    clr = 1'b1;
    clk_step();
    clr = 1'b0;
    chk("t6_busy1", {7'h0, busy}, 8'h01);
    clk_step();
    clk_step();
    chk("t6_busy3", {7'h0, busy}, 8'h01);
    rst_n = 1'b0;
    clk_step();
    rst_n = 1'b1;
    chk("t6_busy_rst", {7'h0, busy}, 8'h00);
    chk("t6_cnt_rst", {4'h0, wr_count}, 8'h00);
    for (int i = 0; i < 8; i++) read_chk("t6_rd", 3'(i), 3'(7 - i), 4'h0, 4'h0);
    write_one(3'd0, 4'h6);
    read_chk("t6_wr", 3'd0, 3'd0, 4'h6, 4'h6);
    chk("t6_cnt_wr", {4'h0, wr_count}, 8'h01);

    // Test 7: random writes and reads against a scoreboard
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 4'h0;
      m_wr[i]  = 1'b0;
    end
    m_mem[0] = 4'h6;
    m_wr[0]  = 1'b1;
    m_cnt    = 1;
    for (int i = 0; i < 64; i++) begin
      load  = ($urandom_range(0, 3) != 0);
      waddr = 3'($urandom_range(0, 7));
      din   = 4'($urandom_range(0, 15));
      if (load) begin
        if (!m_wr[waddr]) m_cnt++;
        m_wr[waddr]  = 1'b1;
        m_mem[waddr] = din;
      end
      clk_step();
      load = 1'b0;
      ra = 3'($urandom_range(0, 7));
      rb = 3'($urandom_range(0, 7));
      read_chk("t7_rd", ra, rb, m_mem[ra], m_mem[rb]);
      chk("t7_cnt", {4'h0, wr_count}, 8'(m_cnt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
